frame_encode8: RTL

- Transmit-side counterpart of the 8-bit Ethernet header decoder.
- Latches a 14-byte Ethernet II header (dest MAC, source MAC, EtherType) on a start pulse and serialises it MSB-first, one byte per accepted beat.
- Then passes the upstream payload byte stream through, and zero-pads the frame to the minimum length.
- Sits between the UDP/IP transmit builder and the MAC transmit interface, ahead of FCS insertion.

---
 rtl/frame_encode8.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frame_encode8.sv
// frame_encode8: Ethernet II transmit framer.
// Captures a 14-byte header on start, then serialises header, payload and
// zero padding up to the minimum frame length through one registered output stage.
module frame_encode8 #(
  parameter int AVL_SIZE  = 8,
  parameter int HDR_BYTES = 14,
  parameter int MIN_FRAME = 60,
  parameter int MAC_SIZE  = 48,
  parameter int BYTE_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [MAC_SIZE-1:0]    dest_mac,
  input  logic [MAC_SIZE-1:0]    source_mac,
  input  logic [2*BYTE_SIZE-1:0] packet_type,
  output logic                   busy,
  input  logic [AVL_SIZE-1:0]    payload_in,
  input  logic                   payload_in_valid,
  input  logic                   payload_in_last,
  output logic                   payload_in_ready,
  output logic [AVL_SIZE-1:0]    data_out,
  output logic                   data_out_valid,
  output logic                   data_out_sop,
  output logic                   data_out_eop,
  input  logic                   data_out_ready
);

  localparam int HDR_W = 2*MAC_SIZE + 2*BYTE_SIZE;
  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   LAST_HDR = (CNT_W+1)'(HDR_BYTES-1);
  localparam logic [CNT_W:0]   EOP_POS  = (CNT_W+1)'(MIN_FRAME-1);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, DONE} state_t;

  state_t state, state_next;

  // Header bytes still to be sent; the next one always sits in the top byte.
  // Byte 0 goes straight from dest_mac to the output, so only bytes 1..13 are kept.
  logic [HDR_W-1:0] hdr;
  logic [CNT_W-1:0] byte_count;
  logic [CNT_W:0]   next_pos;
  logic             out_free;
  logic             out_xfer;
  logic             load;
  logic             load_sop;
  logic             load_eop;
  logic             shift_hdr;
  logic             accept_start;
  logic [AVL_SIZE-1:0] load_data;

  assign out_free = !data_out_valid || data_out_ready;
  assign out_xfer = data_out_valid && data_out_ready;
  // Frame index of the next byte to load: bytes already transferred plus the
  // one that may still be waiting in the output register.
  assign next_pos = {1'b0, byte_count} + {{CNT_W{1'b0}}, data_out_valid};
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and selection of the byte loaded into the output stage.
  always_comb begin
    state_next       = state;
    load             = 1'b0;
    load_sop         = 1'b0;
    load_eop         = 1'b0;
    load_data        = '0;
    shift_hdr        = 1'b0;
    accept_start     = 1'b0;
    payload_in_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          load         = 1'b1;
          load_sop     = 1'b1;
          load_data    = dest_mac[MAC_SIZE-1 -: AVL_SIZE];
          state_next   = HEADER;
        end
      end
      HEADER: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = hdr[HDR_W-1 -: AVL_SIZE];
          shift_hdr = 1'b1;
          if (next_pos == LAST_HDR) state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        payload_in_ready = out_free;
        if (out_free && payload_in_valid) begin
          load      = 1'b1;
          load_data = payload_in;
          if (payload_in_last) begin
            if (next_pos >= EOP_POS) begin
              load_eop   = 1'b1;
              state_next = DONE;
            end else begin
              state_next = PAD;
            end
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load = 1'b1;
          if (next_pos == EOP_POS) begin
            load_eop   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Header capture/shift, transferred-byte counter and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr            <= '0;
      byte_count     <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_sop   <= 1'b0;
      data_out_eop   <= 1'b0;
    end else begin
      if (accept_start)
        hdr <= {dest_mac[MAC_SIZE-BYTE_SIZE-1:0], source_mac, packet_type, {BYTE_SIZE{1'b0}}};
      else if (shift_hdr)
        hdr <= {hdr[HDR_W-BYTE_SIZE-1:0], {BYTE_SIZE{1'b0}}};

      if (accept_start)
        byte_count <= '0;
      else if (out_xfer && byte_count != CNT_MAX)
        byte_count <= byte_count + CNT_W'(1);

      if (load) begin
        data_out       <= load_data;
        data_out_valid <= 1'b1;
        data_out_sop   <= load_sop;
        data_out_eop   <= load_eop;
      end else if (out_xfer) begin
        data_out_valid <= 1'b0;
        data_out_sop   <= 1'b0;
        data_out_eop   <= 1'b0;
      end
    end
  end

endmodule
